// File: rtl/bus_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_scheduler_if
// Brief    : Shared frame/irdy bus bundle with active-low request/grant lines
//            between the requesting masters and the round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_rr_scheduler_if #(
  parameter int N_MASTERS = 3,
  parameter int OWN_W     = $clog2(N_MASTERS)
) ();
  logic                 frame;
  logic                 irdy;
  logic [N_MASTERS-1:0] req_n;
  logic [N_MASTERS-1:0] gnt_n;
  logic [OWN_W-1:0]     owner;
  logic                 busy;
  logic                 preempt;

  // Bus masters drive the bus qualifiers and requests, observe the grants
  modport master (
    output frame, irdy, req_n,
    input  gnt_n, owner, busy, preempt
  );

  // The scheduler observes the bus and drives the grants
  modport slave (
    input  frame, irdy, req_n,
    output gnt_n, owner, busy, preempt
  );
endinterface
`default_nettype wire

// File: rtl/bus_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_scheduler
// Brief    : Round-robin scheduler for N masters on a shared frame/irdy bus.
//            One-cycle turnaround between owners, tenure-limit preemption
//            when another master is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_scheduler #(
  parameter int N_MASTERS  = 3,
  parameter int MAX_TENURE = 16,
  parameter int OWN_W      = $clog2(N_MASTERS),
  parameter int CNT_W      = $clog2(MAX_TENURE + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  bus_rr_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    TURN  = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_TENURE - 1);
  localparam logic [OWN_W-1:0] LAST_RST  = OWN_W'(N_MASTERS - 1);

  state_t               state;
  logic [N_MASTERS-1:0] gnt_n_q;
  logic [OWN_W-1:0]     owner_q;
  logic [OWN_W-1:0]     last_q;
  logic [CNT_W-1:0]     tenure;
  logic                 busy_q;
  logic                 preempt_q;

  logic                 done;
  logic                 found;
  logic [OWN_W-1:0]     winner;
  logic [OWN_W-1:0]     idx;
  logic [N_MASTERS-1:0] win_gnt_n;
  logic [N_MASTERS-1:0] others;

  assign done = bus.frame && bus.irdy;

  // Rotating priority search starting just after the last granted master
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    idx       = '0;
    win_gnt_n = '1;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = OWN_W'((int'(last_q) + i) % N_MASTERS);
      if (!found && !bus.req_n[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    win_gnt_n[winner] = 1'b0;
  end

  // Requests from anyone other than the current owner (owner's own bit ignored)
  always_comb begin
    others          = ~bus.req_n;
    others[owner_q] = 1'b0;
  end

  // Scheduler FSM with registered grant, owner, busy and preempt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt_n_q   <= '1;
      owner_q   <= '0;
      last_q    <= LAST_RST;
      tenure    <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (found) begin
            state   <= GRANT;
            last_q  <= winner;
            owner_q <= winner;
            gnt_n_q <= win_gnt_n;
            busy_q  <= 1'b1;
            tenure  <= '0;
          end else begin
            state   <= IDLE;
            gnt_n_q <= '1;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (tenure != CNT_MAX) begin
            tenure <= tenure + 1'b1;
          end
          // done wins over the tenure limit when both occur together
          if (done) begin
            state   <= TURN;
            gnt_n_q <= '1;
            busy_q  <= 1'b0;
          end else if ((tenure == CNT_LIMIT) && (|others)) begin
            state     <= TURN;
            gnt_n_q   <= '1;
            busy_q    <= 1'b0;
            preempt_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_n_q <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_n   = gnt_n_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

`ifdef FORMAL
  // Grant shape, busy consistency, turnaround gap and state reachability
  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(~gnt_n_q));
      assert (busy_q == (gnt_n_q != '1));
      cover (state == IDLE);
      cover (state == GRANT);
      cover (state == TURN);
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    (gnt_n_q != '1) |=> ((gnt_n_q == '1) || $stable(gnt_n_q)));

  // Per-master wait counters bounding how long a held request goes ungranted
  generate
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_fair
      logic [15:0] wait_cnt;
      always @(posedge clk) begin
        if (reset || bus.req_n[g] || !gnt_n_q[g]) begin
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
      assert property (@(posedge clk) disable iff (reset)
        wait_cnt <= 16'((N_MASTERS - 1) * (MAX_TENURE + 1) + 1));
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rr_scheduler
// Brief    : Randomized self-checking bench for bus_rr_scheduler against a
//            cycle-level behavioural model of the rotation/tenure rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rr_scheduler;
  localparam int N    = 3;
  localparam int MAXT = 16;
  localparam int OW   = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Model: who holds the bus (-1 none), last owner, rotation pointer, grant age
  int   m_active;
  int   m_owner;
  int   m_last;
  int   m_held;
  bit   m_pre;

  always #5 clk = ~clk;

  bus_rr_scheduler_if #(.N_MASTERS(N)) bus ();

  bus_rr_scheduler #(.N_MASTERS(N), .MAX_TENURE(MAXT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit other_waiting(input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      if (i != m_active && req[i] == 1'b0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock edge of the scheduling rules
  task automatic model_update(input bit rst, input logic [N-1:0] req, input bit done);
    if (rst) begin
      m_active = -1;
      m_owner  = 0;
      m_last   = N - 1;
      m_held   = 0;
      m_pre    = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_active >= 0) begin
        m_held++;
        if (done) begin
          m_active = -1;
        end else if (m_held == MAXT && other_waiting(req)) begin
          m_active = -1;
          m_pre    = 1'b1;
        end
      end else begin
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (m_last + i) % N;
          if (m_active < 0 && req[k] == 1'b0) begin
            m_active = k;
            m_owner  = k;
            m_last   = k;
            m_held   = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] e;
    e = '1;
    if (m_active >= 0) e[m_active] = 1'b0;
    return e;
  endfunction

  task automatic set_done(input bit d);
    int r;
    if (d) begin
      bus.frame = 1'b1;
      bus.irdy  = 1'b1;
    end else begin
      r = $urandom_range(0, 2);
      bus.frame = r[1];
      bus.irdy  = r[0];
    end
  endtask

  // Advance one edge, update the model from the applied inputs, compare
  task automatic step();
    bit d;
    d = bus.frame && bus.irdy;
    @(posedge clk);
    model_update(reset, bus.req_n, d);
    #1;
    check("gnt_n",   32'(bus.gnt_n),   32'(exp_gnt()));
    check("owner",   32'(bus.owner),   32'(m_owner));
    check("busy",    32'(bus.busy),    32'(m_active >= 0));
    check("preempt", 32'(bus.preempt), 32'(m_pre));
  endtask

  initial begin
    reset     = 1'b1;
    bus.req_n = '1;
    bus.frame = 1'b0;
    bus.irdy  = 1'b0;
    m_active  = -1;
    m_owner   = 0;
    m_last    = N - 1;
    m_held    = 0;
    m_pre     = 1'b0;

    // Reset state
    step();
    step();
    check("rst_gnt_n", 32'(bus.gnt_n), 32'h7);
    check("rst_owner", 32'(bus.owner), 32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    reset = 1'b0;

    // Single request from master 1, done one cycle after the grant
    bus.req_n = 3'b101;
    set_done(1'b0);
    step();
    check("m1_grant", 32'(bus.gnt_n), 32'h5);
    check("m1_owner", 32'(bus.owner), 32'h1);
    set_done(1'b1);
    step();
    bus.req_n = 3'b111;
    set_done(1'b0);
    step();
    step();

    // Mixed random requests and completions
    for (int c = 0; c < 500; c++) begin
      bus.req_n = N'($urandom);
      set_done($urandom_range(0, 99) < 15);
      step();
    end

    // Everyone requesting, rare completions: rotation and preemption
    for (int c = 0; c < 300; c++) begin
      bus.req_n = '0;
      set_done($urandom_range(0, 99) < 3);
      step();
    end

    // Completion landing exactly on the tenure-limit edge
    for (int c = 0; c < 200; c++) begin
      bus.req_n = N'($urandom) & 3'b110;
      set_done(m_active >= 0 && m_held == MAXT - 1);
      step();
    end

    // Master 0 as sole requester with no completion: grant held, no preempt
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_n = 3'b110;
    for (int c = 0; c < 40; c++) begin
      set_done(1'b0);
      step();
    end
    check("sole_hold", 32'(bus.gnt_n), 32'h6);
    // A late second requester does not trigger a preemption past the limit
    bus.req_n = 3'b010;
    for (int c = 0; c < 20; c++) begin
      set_done(1'b0);
      step();
    end
    check("late_hold", 32'(bus.gnt_n), 32'h6);

    // Random traffic with occasional mid-transaction resets
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) < 3);
      bus.req_n = N'($urandom);
      set_done($urandom_range(0, 99) < 10);
      step();
    end
    reset = 1'b0;

    // Reset while master 2 owns the bus, then all request: master 0 first
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_n = 3'b011;
    set_done(1'b0);
    step();
    check("m2_grant", 32'(bus.gnt_n), 32'h3);
    reset = 1'b1;
    step();
    check("rst_mid_gnt",   32'(bus.gnt_n), 32'h7);
    check("rst_mid_owner", 32'(bus.owner), 32'h0);
    reset = 1'b0;
    bus.req_n = 3'b000;
    step();
    check("post_rst_m0", 32'(bus.gnt_n), 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
